// File: rtl/dmem_sram_bridge.sv
// Bridges the pipeline data-memory port to an asynchronous SRAM with active-low strobes.
// One access at a time; the pipeline is stalled from accept until the DONE cycle.
module dmem_sram_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dm_req_i,
    input  logic               dm_re_i,
    input  logic               dm_we_i,
    input  logic [31:0]        dm_addr_i,
    input  logic [3:0]         dm_be_n_i,
    input  logic [31:0]        dm_wdata_i,
    output logic               dm_stall_o,
    output logic [31:0]        dm_rdata_o,
    output logic               dm_rvalid_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_data_o,
    input  logic [31:0]        sram_data_i,
    output logic               sram_data_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o
);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StWrHold, StDone} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       accept;
    logic       unused_addr;

    assign accept     = (state_q == StIdle) && dm_req_i && (dm_re_i || dm_we_i);
    assign dm_stall_o = accept || (state_q inside {StRd, StWr, StWrHold});

    // Byte offset and bits above the SRAM word range are deliberately dropped.
    assign unused_addr = ^{dm_addr_i[31:SRAM_AW+2], dm_addr_i[1:0]};

    // Strobes are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            dm_rvalid_o    <= 1'b0;
            dm_rdata_o     <= '0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'hF;
        end else begin
            dm_rvalid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sram_addr_o <= dm_addr_i[SRAM_AW+1:2];
                        sram_data_o <= dm_wdata_i;
                        sram_be_n_o <= dm_be_n_i;
                        sram_ce_n_o <= 1'b0;
                        cnt_q       <= 4'(WAIT_CYCLES);
                        if (dm_we_i) begin
                            state_q        <= StWr;
                            sram_we_n_o    <= 1'b0;
                            sram_data_oe_o <= 1'b1;
                        end else begin
                            state_q     <= StRd;
                            sram_oe_n_o <= 1'b0;
                        end
                    end
                end
                StRd: begin
                    if (cnt_q == 4'd0) begin
                        dm_rdata_o  <= sram_data_i;
                        dm_rvalid_o <= 1'b1;
                        state_q     <= StDone;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_be_n_o <= 4'hF;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWr: begin
                    if (cnt_q == 4'd0) begin
                        sram_we_n_o <= 1'b1;
                        state_q     <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWrHold: begin
                    sram_ce_n_o    <= 1'b1;
                    sram_data_oe_o <= 1'b0;
                    sram_be_n_o    <= 4'hF;
                    state_q        <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM access cycles beyond one, range 0..15.
REQ-002 SHALL have parameter SRAM_AW, default 20: SRAM word-address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, as the ports below.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 dm_req_i  in  1  pipeline memory request valid; held stable while dm_stall_o=1.
REQ-007 dm_re_i / dm_we_i  in  1 each  read / write select.
REQ-008 dm_addr_i  in  32  byte address.
REQ-009 dm_be_n_i  in  4  active-low byte enables.
REQ-010 dm_wdata_i  in  32  store data, already lane-aligned.
REQ-011 dm_stall_o  out  1  freeze pipeline.
REQ-012 dm_rdata_o  out  32  full word of load data.
REQ-013 dm_rvalid_o  out  1  dm_rdata_o valid this cycle.
REQ-014 sram_addr_o  out  SRAM_AW  word address.
REQ-015 sram_data_o  out  32  write data.
REQ-016 sram_data_i  in  32  read data.
REQ-017 sram_data_oe_o  out  1  drive data bus.
REQ-018 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes.
REQ-019 sram_be_n_o  out  4  active-low byte enables.

Function
REQ-020 FSM states SHALL be IDLE, RD, WR, WR_HOLD, DONE.
REQ-021 IDLE: accept when dm_req_i & (dm_re_i | dm_we_i); latch addr[SRAM_AW+1:2], be_n, wdata, op; go to WR if dm_we_i else RD.
REQ-022 dm_we_i & dm_re_i together SHALL be treated as a write.
REQ-023 Access counter SHALL load WAIT_CYCLES on accept, decrement in RD/WR, leave on count 0; RD and WR each last WAIT_CYCLES+1 cycles.
REQ-024 RD: ce_n=0, oe_n=0, we_n=1, be_n=latched, oe=0; on last RD cycle capture sram_data_i into rdata register; next DONE.
REQ-025 WR: ce_n=0, oe_n=1, we_n=0, be_n=latched, oe=1, sram_data_o=latched wdata; next WR_HOLD.
REQ-026 WR_HOLD: one cycle, ce_n=0, we_n=1, oe=1, address/data held; next DONE.
REQ-027 DONE: all strobes inactive, oe=0, stall=0; dm_rvalid_o=1 only if op was read; next IDLE unconditionally.
REQ-028 dm_stall_o SHALL be 1 in IDLE when a request is accepted (combinational), and in RD, WR, WR_HOLD; 0 in DONE and idle-without-request.
REQ-029 Latency: read = WAIT_CYCLES+3 cycles accept-to-DONE inclusive; write = WAIT_CYCLES+4.
REQ-030 dm_rdata_o SHALL hold last captured word until next read capture.
REQ-031 Inputs changing after accept SHALL be ignored; only latched values drive SRAM.
REQ-032 A request present in DONE SHALL NOT be accepted; back-to-back requests accepted from the following IDLE cycle.
REQ-033 Address bits [1:0] and [31:SRAM_AW+2] SHALL be ignored; no alignment check.
REQ-034 sram_addr_o SHALL be stable throughout RD, WR, WR_HOLD.

Reset
REQ-035 rst=1 SHALL on the next edge force IDLE from any state, counter 0, rdata 0.
REQ-036 Reset values: dm_stall_o=0, dm_rvalid_o=0, dm_rdata_o=0, ce_n/oe_n/we_n=1, sram_be_n_o=4'hF, sram_data_oe_o=0, sram_addr_o=0, sram_data_o=0.
REQ-037 Reset mid-WR SHALL deassert sram_we_n_o the cycle after the reset edge; no DONE/rvalid emitted.

Verification
REQ-038 Read, WAIT_CYCLES=1: addr 0x0000_0104, SRAM word 0xDEADBEEF -> sram_addr_o=0x41, stall high 3 cycles, rvalid cycle 4 with rdata 0xDEADBEEF.
REQ-039 Write: addr 0x10, be_n 4'b1100, wdata 0x0000_A5A5 -> we_n low 2 cycles, then 1 hold cycle, bus driven throughout, be_n=1100; stall 4 cycles; no rvalid.
REQ-040 Back-to-back: write then read same address -> read issued after DONE; returns written lanes.
REQ-041 WAIT_CYCLES=0 read -> stall 2 cycles, rvalid on 3rd cycle.
REQ-042 Reset asserted in 2nd WR cycle -> next cycle all reset values, IDLE, no rvalid.
REQ-043 re=we=1 request -> write sequence performed, no rvalid.
